// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if
// Groups the block handshake and data buses of the iterative AES cipher.
//   start    : request to encrypt in_data (driven by master)
//   in_data  : 128-bit plaintext, byte k = in_data[8k +: 8] (master)
//   word     : expanded key, round key r = word[128*r +: 128] (master)
//   out_data : registered ciphertext (slave)
//   busy     : block in flight (slave)
//   done     : one-cycle completion pulse (slave)
// The nr parameter must match the cipher instance it connects to.
interface aes_cipher_iter_if #(
  parameter int nr = 10
);
  logic                     start;
  logic [0:127]             in_data;
  logic [0:128*(nr+1)-1]    word;
  logic [0:127]             out_data;
  logic                     busy;
  logic                     done;

  modport master (
    output start, in_data, word,
    input  out_data, busy, done
  );

  modport slave (
    input  start, in_data, word,
    output out_data, busy, done
  );
endinterface

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter
// Iterative AES encryption core, one round per clock. Consumes the full
// expanded key vector from the key-expansion stage (not latched; it must be
// held stable for the whole block). Ciphertext is registered and held until
// the next block completes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_cipher_iter_if.slave (start/in_data/word in,
//           out_data/busy/done out)
// Parameters:
//   nk : key length in 32-bit words (4/6/8), sizing only
//   nr : number of rounds (10/12/14)
module aes_cipher_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_cipher_iter_if.slave   bus
);

  localparam int RW = $clog2(nr + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(nr);

  // AES key size and round count are tied; catch a mismatched pairing early.
  if (nr != nk + 6) begin : g_bad_cfg
    $error("aes_cipher_iter: nr must equal nk + 6");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t            fsm, fsm_nxt;
  logic [0:127]    state, state_nxt;
  logic [RW-1:0]   round, round_nxt;
  logic [0:127]    out_reg, out_nxt;
  logic            busy_reg, busy_nxt;
  logic            done_reg, done_nxt;

  logic [0:127]    round_key;
  logic [0:127]    sub_shifted;
  logic [0:127]    mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows together: byte (row, col) of the result comes
  // from byte (row, col+row mod 4) of the input, after the S-box.
  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(4*c+row) +: 8] = SBOX[s[8*(4*((c+row)%4)+row) +: 8]];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign round_key   = bus.word[128*int'(round) +: 128];
  assign sub_shifted = sub_shift(state);
  assign mixed       = mix_columns(sub_shifted);

  // Next-state and datapath decisions. The last round skips MixColumns and
  // writes straight into the output register instead of the state.
  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state;
    round_nxt = round;
    out_nxt   = out_reg;
    busy_nxt  = busy_reg;
    done_nxt  = 1'b0;
    case (fsm)
      IDLE: begin
        if (bus.start) begin
          state_nxt = bus.in_data ^ bus.word[0 +: 128];
          round_nxt = RW'(1);
          busy_nxt  = 1'b1;
          fsm_nxt   = RUN;
        end
      end
      RUN: begin
        if (round == LAST_ROUND) begin
          out_nxt  = sub_shifted ^ round_key;
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          fsm_nxt  = IDLE;
        end else begin
          state_nxt = mixed ^ round_key;
          round_nxt = round + RW'(1);
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // All state, including the visible outputs, is cleared by reset so an
  // aborted block leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      state    <= '0;
      round    <= '0;
      out_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      fsm      <= fsm_nxt;
      state    <= state_nxt;
      round    <= round_nxt;
      out_reg  <= out_nxt;
      busy_reg <= busy_nxt;
      done_reg <= done_nxt;
    end
  end

  assign bus.out_data = out_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter
// Directed bench for aes_cipher_iter: FIPS-197 vectors for AES-128 and
// AES-256, back-to-back and ignored starts, mid-block reset and output hold.
// The expanded key driven on `word` is generated here from an independent
// S-box built from the GF(2^8) inverse plus the affine transform.
module tb_aes_cipher_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  aes_cipher_iter_if #(.nr(10)) bus128 ();
  aes_cipher_iter_if #(.nr(14)) bus256 ();

  aes_cipher_iter #(.nk(4), .nr(10)) dut128 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus128)
  );

  aes_cipher_iter #(.nk(8), .nr(14)) dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus256)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sbox_model [256];

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_model[w[31:24]], sbox_model[w[23:16]],
            sbox_model[w[15:8]], sbox_model[w[7:0]]};
  endfunction

  // Standard FIPS-197 key expansion; key is left-aligned in 256 bits and the
  // schedule is left-aligned in the result (round key 0 first).
  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [0:1919] res;
    int           nwords;
    nwords = 4 * (nk + 7);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nwords; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic check_output(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulses start for one edge and waits (bounded) for done. Returns the
  // number of edges from the accepting edge to done, and how many post-edge
  // samples showed busy high.
  task automatic apply_stimulus(input bit wide, input logic [127:0] pt,
                                output int lat, output int busy_cnt);
    if (wide) begin
      bus256.in_data = pt;
      bus256.start   = 1'b1;
    end else begin
      bus128.in_data = pt;
      bus128.start   = 1'b1;
    end
    @(posedge clk); #1;
    bus256.start = 1'b0;
    bus128.start = 1'b0;
    lat = 0;
    busy_cnt = (wide ? bus256.busy : bus128.busy) ? 1 : 0;
    while (!(wide ? bus256.done : bus128.done) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (wide ? bus256.busy : bus128.busy) busy_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busy_cnt;
    int dones;
    int first_done;
    logic [0:1919] sched;

    bus128.start = 1'b0;
    bus128.in_data = '0;
    bus128.word = '0;
    bus256.start = 1'b0;
    bus256.in_data = '0;
    bus256.word = '0;

    build_sbox();
    sched = expand_key(KEY_C1, 4);
    bus128.word = sched[0 +: 1408];
    sched = expand_key(KEY_C3, 8);
    bus256.word = sched[0 +: 1920];

    // Reset state
    #2;
    check_output("reset_out128", bus128.out_data, 128'h0);
    check_output("reset_busy128", 128'(bus128.busy), 128'h0);
    check_output("reset_done128", 128'(bus128.done), 128'h0);
    check_output("reset_out256", bus256.out_data, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 C.1, AES-128
    apply_stimulus(1'b0, C1_PT, lat, busy_cnt);
    check_output("c1_ct", bus128.out_data, C1_CT);
    check_output("c1_latency", 128'(lat), 128'd10);
    check_output("c1_busy_cycles", 128'(busy_cnt), 128'd10);

    // Hold: inputs churn without start, output must not move
    dones = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus128.in_data = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 44; j++) bus128.word[32*j +: 32] = $urandom;
      @(posedge clk); #1;
      if (bus128.done) dones++;
      if (bus128.busy) busy_cnt++;
    end
    check_output("hold_out", bus128.out_data, C1_CT);
    check_output("hold_done_count", 128'(dones), 128'd0);
    check_output("hold_busy_count", 128'(busy_cnt), 128'd0);
    sched = expand_key(KEY_C1, 4);
    bus128.word = sched[0 +: 1408];

    // Back-to-back: second start during the done cycle, stray start mid-run
    apply_stimulus(1'b0, C1_PT, lat, busy_cnt);
    check_output("b2b_first_ct", bus128.out_data, C1_CT);
    check_output("b2b_first_latency", 128'(lat), 128'd10);
    bus128.in_data = C1_PT;
    bus128.start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    first_done = -1;
    for (int i = 1; i <= 30; i++) begin
      bus128.start = (i == 4);
      @(posedge clk); #1;
      if (bus128.done) begin
        dones++;
        if (first_done < 0) first_done = i;
        check_output("b2b_second_ct", bus128.out_data, C1_CT);
      end
    end
    bus128.start = 1'b0;
    check_output("b2b_done_count", 128'(dones), 128'd1);
    check_output("b2b_second_latency", 128'(first_done), 128'd10);

    // Reset in the middle of a block
    bus128.in_data = C1_PT;
    bus128.start = 1'b1;
    @(posedge clk); #1;
    bus128.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", 128'(bus128.busy), 128'h0);
    check_output("midrst_done", 128'(bus128.done), 128'h0);
    check_output("midrst_out", bus128.out_data, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus128.done) dones++;
    end
    check_output("midrst_no_done", 128'(dones), 128'd0);
    apply_stimulus(1'b0, C1_PT, lat, busy_cnt);
    check_output("midrst_recover_ct", bus128.out_data, C1_CT);
    check_output("midrst_recover_latency", 128'(lat), 128'd10);

    // FIPS-197 Appendix B, AES-128
    sched = expand_key(KEY_B, 4);
    bus128.word = sched[0 +: 1408];
    apply_stimulus(1'b0, B_PT, lat, busy_cnt);
    check_output("appb_ct", bus128.out_data, B_CT);
    check_output("appb_latency", 128'(lat), 128'd10);

    // FIPS-197 C.3, AES-256
    apply_stimulus(1'b1, C1_PT, lat, busy_cnt);
    check_output("c3_ct", bus256.out_data, C3_CT);
    check_output("c3_latency", 128'(lat), 128'd14);
    check_output("c3_busy_cycles", 128'(busy_cnt), 128'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
